shift_load_ctrl: RTL

Sequencer that feeds the 16-bit serial-in/parallel-out shift register from a serial bit stream and turns each completed word into an addressed write toward instruction/data memory. It sits between a serial boot/load source and the memory write port: it drives the shift register's enable and serial input, counts bits, and reads back the parallel word. It runs a ready/valid handshake on both sides and walks consecutive addresses from 0.

---
 rtl/shift_load_ctrl.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/shift_load_ctrl.sv
// Serial-bit to addressed-word load sequencer for an external 16-bit SIPO shift register.
// Optional odd-parity bit per word is enabled by defining SHIFT_LOAD_PARITY_EN.
module shift_load_ctrl #(
    parameter int WORD_W = 16,
    parameter int ADDR_W = 15
) (
    input  logic              clk,
    input  logic              resetb,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] num_words_i,
    input  logic              bit_valid_i,
    input  logic              bit_i,
    output logic              bit_ready_o,
    output logic              sr_en_o,
    output logic              sr_in_o,
    input  logic [WORD_W-1:0] sr_word_i,
    output logic              wr_valid_o,
    input  logic              wr_ready_i,
    output logic [ADDR_W-1:0] wr_addr_o,
    output logic [WORD_W-1:0] wr_data_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o
);

    localparam int CNT_W = $clog2(WORD_W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_W - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SHIFT  = 3'd1,
`ifdef SHIFT_LOAD_PARITY_EN
        PARITY = 3'd2,
`endif
        WRITE  = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] num_words;
    logic [ADDR_W-1:0] addr;
    logic [CNT_W-1:0]  bit_cnt;
    logic              busy;
    logic              last_word;

`ifdef SHIFT_LOAD_PARITY_EN
    logic              par;
    logic              err;
`endif

    assign last_word = (addr == num_words - ADDR_W'(1));

    always_comb begin
        state_nxt   = state;
        bit_ready_o = 1'b0;
        sr_en_o     = 1'b0;
        sr_in_o     = 1'b0;
        wr_valid_o  = 1'b0;
        done_o      = 1'b0;
        case (state)
            IDLE: begin
                if (start_i) begin
                    state_nxt = (num_words_i == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                bit_ready_o = 1'b1;
                if (bit_valid_i) begin
                    sr_en_o = 1'b1;
                    sr_in_o = bit_i;
                    if (bit_cnt == LAST_BIT) begin
`ifdef SHIFT_LOAD_PARITY_EN
                        state_nxt = PARITY;
`else
                        state_nxt = WRITE;
`endif
                    end
                end
            end
`ifdef SHIFT_LOAD_PARITY_EN
            // Parity bit is consumed here without clocking the shift register.
            PARITY: begin
                bit_ready_o = 1'b1;
                if (bit_valid_i) begin
                    state_nxt = WRITE;
                end
            end
`endif
            WRITE: begin
                wr_valid_o = 1'b1;
                if (wr_ready_i) begin
                    state_nxt = last_word ? DONE : SHIFT;
                end
            end
            DONE: begin
                done_o    = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state     <= IDLE;
            busy      <= 1'b0;
            num_words <= '0;
            addr      <= '0;
            bit_cnt   <= '0;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt != IDLE);
            if (state == IDLE && start_i) begin
                num_words <= num_words_i;
                addr      <= '0;
                bit_cnt   <= '0;
            end
            // Counter wraps to 0 naturally after the last bit of a word.
            if (state == SHIFT && bit_valid_i) begin
                bit_cnt <= bit_cnt + CNT_W'(1);
            end
            if (state == WRITE && wr_ready_i && !last_word) begin
                addr <= addr + ADDR_W'(1);
            end
        end
    end

`ifdef SHIFT_LOAD_PARITY_EN
    // Odd parity: XOR over data bits plus parity bit must be 1; error is sticky per session.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            par <= 1'b0;
            err <= 1'b0;
        end else begin
            if (state == IDLE && start_i) begin
                par <= 1'b0;
                err <= 1'b0;
            end
            if (state == SHIFT && bit_valid_i) begin
                par <= par ^ bit_i;
            end
            if (state == PARITY && bit_valid_i) begin
                par <= 1'b0;
                if (!(par ^ bit_i)) begin
                    err <= 1'b1;
                end
            end
        end
    end
    assign err_o = err;
`else
    assign err_o = 1'b0;
`endif

    assign busy_o    = busy;
    assign wr_addr_o = addr;
    assign wr_data_o = sr_word_i;

endmodule
